// File: rtl/reg_decr_nstage_valrdy.sv
// reg_decr_nstage_valrdy: elastic val/rdy pipeline decrementing by one per stage; REG_DECR_NSTAGE_SAT_EN selects saturating decrement
module reg_decr_nstage_valrdy #(
  parameter int p_nstages = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_val,
  output logic       in_rdy,
  input  logic [7:0] in_msg,
  output logic       out_val,
  input  logic       out_rdy,
  output logic [7:0] out_msg,
  output logic [3:0] occupancy
);
  logic [p_nstages-1:0]      val_q, val_d;
  logic [p_nstages-1:0][7:0] dat_q, dat_d;
  logic [p_nstages:0]        rdy;
  logic [3:0]                occ_q, occ_d;
  logic                      in_xfer;
  function automatic logic [7:0] dec(input logic [7:0] x);
`ifdef REG_DECR_NSTAGE_SAT_EN
    return x == 8'h00 ? 8'h00 : x - 8'd1;
`else
    return x - 8'd1;
`endif
  endfunction
  always_comb begin
    rdy = '0;
    rdy[p_nstages] = out_rdy;
    for (int k = p_nstages - 1; k >= 0; k--) rdy[k] = !val_q[k] || rdy[k+1];
    in_rdy = !reset && rdy[0];
    in_xfer = in_val && in_rdy;
    val_d = '0;
    dat_d = '0;
    val_d[0] = in_xfer || (val_q[0] && !rdy[1]);
    dat_d[0] = in_xfer ? dec(in_msg) : dat_q[0];
    for (int k = 1; k < p_nstages; k++) begin
      val_d[k] = (val_q[k-1] && rdy[k]) || (val_q[k] && !rdy[k+1]);
      dat_d[k] = (val_q[k-1] && rdy[k]) ? dec(dat_q[k-1]) : dat_q[k];
    end
    occ_d = '0;
    for (int k = 0; k < p_nstages; k++) occ_d = occ_d + 4'(val_d[k]);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      val_q <= '0;
      dat_q <= '0;
      occ_q <= '0;
    end else begin
      val_q <= val_d;
      dat_q <= dat_d;
      occ_q <= occ_d;
    end
  end
  assign out_val   = val_q[p_nstages-1];
  assign out_msg   = dat_q[p_nstages-1];
  assign occupancy = occ_q;
endmodule

// File: tb/tb_reg_decr_nstage_valrdy.sv
// tb_reg_decr_nstage_valrdy: directed vector table on a 2-stage instance plus corner sequences on a 3-stage instance
module tb_reg_decr_nstage_valrdy;
  logic clk;
  logic r2, iv2, ir2, ov2, or2;
  logic [7:0] im2, om2;
  logic [3:0] occ2;
  logic r3, iv3, ir3, ov3, or3;
  logic [7:0] im3, om3;
  logic [3:0] occ3;
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct {
    logic       iv;
    logic [7:0] im;
    logic       ordy;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_om;
    logic [3:0] e_occ;
  } vec_t;
  vec_t vecs[$];
`ifdef REG_DECR_NSTAGE_SAT_EN
  localparam logic [7:0] wrap_exp = 8'h00;
`else
  localparam logic [7:0] wrap_exp = 8'hFF;
`endif
  reg_decr_nstage_valrdy #(.p_nstages(2)) dut2 (
    .clk(clk), .reset(r2), .in_val(iv2), .in_rdy(ir2), .in_msg(im2),
    .out_val(ov2), .out_rdy(or2), .out_msg(om2), .occupancy(occ2)
  );
  reg_decr_nstage_valrdy #(.p_nstages(3)) dut3 (
    .clk(clk), .reset(r3), .in_val(iv3), .in_rdy(ir3), .in_msg(im3),
    .out_val(ov3), .out_rdy(or3), .out_msg(om3), .occupancy(occ3)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask
  task automatic add(input logic iv, input logic [7:0] im, input logic ordy, input logic e_ir,
                     input logic e_ov, input logic [7:0] e_om, input logic [3:0] e_occ);
    vecs.push_back('{iv, im, ordy, e_ir, e_ov, e_om, e_occ});
  endtask
  initial begin
    int acc;
    int got;
    logic seen;
    logic [7:0] exp_q[$];
    clk = 0;
    r2 = 1; iv2 = 0; im2 = 0; or2 = 1;
    r3 = 1; iv3 = 0; im3 = 0; or3 = 0;
    // single message latency, back-to-back stream
    add(1, 8'h05, 1, 1, 0, 8'h00, 0);
    add(0, 8'hAA, 1, 1, 0, 8'h00, 1);
    add(0, 8'hAA, 1, 1, 1, 8'h03, 1);
    add(1, 8'h10, 1, 1, 0, 8'h00, 0);
    add(1, 8'h11, 1, 1, 0, 8'h00, 1);
    add(1, 8'h12, 1, 1, 1, 8'h0E, 2);
    add(0, 8'h00, 1, 1, 1, 8'h0F, 2);
    add(0, 8'h00, 1, 1, 1, 8'h10, 1);
    add(0, 8'h00, 1, 1, 0, 8'h00, 0);
    // fill under backpressure, then simultaneous accept/emit when full
    add(1, 8'h20, 0, 1, 0, 8'h00, 0);
    add(1, 8'h21, 0, 1, 0, 8'h00, 1);
    add(1, 8'h22, 0, 0, 1, 8'h1E, 2);
    add(1, 8'h22, 0, 0, 1, 8'h1E, 2);
    add(1, 8'h22, 1, 1, 1, 8'h1E, 2);
    add(0, 8'h00, 0, 0, 1, 8'h1F, 2);
    add(0, 8'h00, 1, 1, 1, 8'h1F, 2);
    add(0, 8'h00, 1, 1, 1, 8'h20, 1);
    add(0, 8'h00, 1, 1, 0, 8'h00, 0);
    // decrement past zero
    add(1, 8'h01, 1, 1, 0, 8'h00, 0);
    add(0, 8'h00, 1, 1, 0, 8'h00, 1);
    add(0, 8'h00, 1, 1, 1, wrap_exp, 1);
    add(0, 8'h00, 1, 1, 0, 8'h00, 0);
    repeat (2) begin
      @(negedge clk);
      iv2 = 1; iv3 = 1;
      #1 chk("rst_in_rdy2", int'(ir2), 0);
      chk("rst_in_rdy3", int'(ir3), 0);
    end
    iv3 = 0;
    foreach (vecs[i]) begin
      @(negedge clk);
      if (i == 0) begin r2 = 0; r3 = 0; end
      iv2 = vecs[i].iv; im2 = vecs[i].im; or2 = vecs[i].ordy;
      #1;
      if (i == 0) chk("post_rst_msg", int'(om2), 0);
      chk($sformatf("v%0d_in_rdy", i), int'(ir2), int'(vecs[i].e_ir));
      chk($sformatf("v%0d_out_val", i), int'(ov2), int'(vecs[i].e_ov));
      chk($sformatf("v%0d_occ", i), int'(occ2), int'(vecs[i].e_occ));
      if (vecs[i].e_ov) chk($sformatf("v%0d_out_msg", i), int'(om2), int'(vecs[i].e_om));
    end
    // reset with two messages in flight
    @(negedge clk); iv2 = 1; im2 = 8'h40; or2 = 1;
    @(negedge clk); im2 = 8'h41;
    @(negedge clk); iv2 = 0; r2 = 1;
    #1 chk("pre_rst_occ", int'(occ2), 2);
    @(negedge clk); r2 = 0;
    #1 chk("mid_rst_out_val", int'(ov2), 0);
    chk("mid_rst_occ", int'(occ2), 0);
    chk("mid_rst_in_rdy", int'(ir2), 1);
    seen = 0;
    repeat (6) begin
      @(negedge clk); #1 if (ov2) seen = 1;
    end
    chk("flushed_never_emitted", int'(seen), 0);
    // 3-stage: offer five messages with out_rdy low
    acc = 0;
    repeat (5) begin
      @(negedge clk);
      iv3 = 1; im3 = 8'h50 + 8'(acc);
      #1 if (ir3) acc++;
    end
    @(negedge clk); iv3 = 0;
    #1 chk("s3_accepted", acc, 3);
    chk("s3_full_in_rdy", int'(ir3), 0);
    chk("s3_full_occ", int'(occ3), 3);
    chk("s3_full_out_val", int'(ov3), 1);
    chk("s3_full_out_msg", int'(om3), 'h4D);
    repeat (3) @(negedge clk);
    #1 chk("s3_stable_msg", int'(om3), 'h4D);
    chk("s3_stable_val", int'(ov3), 1);
    exp_q = '{8'h4D, 8'h4E, 8'h4F};
    got = 0;
    or3 = 1;
    for (int c = 0; c < 20 && got < 3; c++) begin
      #1 if (ov3) begin
        chk($sformatf("s3_drain%0d", got), int'(om3), int'(exp_q[got]));
        got++;
      end
      @(negedge clk);
    end
    chk("s3_drain_count", got, 3);
    #1 chk("s3_drained_occ", int'(occ3), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
